alu_hilo: RTL and testbench

ALU_HILO -- requirements
Module: alu_hilo

---
 rtl/alu_hilo.sv | 123 ++++++++++++
 tb/tb_alu_hilo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_hilo.sv
// alu_hilo: combinational ALU with HI/LO registers for multiply, divide and move ops.
// Define ALU_HILO_DIV_EN to build the Div/Divu datapath; otherwise those codes act as None.
module alu_hilo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DELAY  = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         data1,
    input  logic [DATA_W-1:0]         data2,
    input  logic [4:0]                func,
    input  logic [$clog2(DATA_W)-1:0] shamt,
    output logic [DATA_W-1:0]         result,
    output logic [3:0]                status
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned MSB    = DATA_W - 1;

    typedef enum logic [4:0] {
        FN_NONE = 5'd0,  FN_ADD  = 5'd1,  FN_ADDU = 5'd2,  FN_SUB  = 5'd3,
        FN_SUBU = 5'd4,  FN_AND  = 5'd5,  FN_OR   = 5'd6,  FN_XOR  = 5'd7,
        FN_NOR  = 5'd8,  FN_SLT  = 5'd9,  FN_SLTU = 5'd10, FN_SLL  = 5'd11,
        FN_SRL  = 5'd12, FN_SRA  = 5'd13, FN_MULT = 5'd14, FN_MULU = 5'd15,
        FN_DIV  = 5'd16, FN_DIVU = 5'd17, FN_MFHI = 5'd18, FN_MFLO = 5'd19,
        FN_MTHI = 5'd20, FN_MTLO = 5'd21
    } func_e;

    func_e             op;
    logic [DATA_W-1:0] hi, lo, hi_nxt, lo_nxt, res;
    logic [DATA_W:0]   sum_ext, diff_ext;
    logic [PROD_W-1:0] prod_s, prod_u;
    logic              carry, overflow;
    logic              unused_delay;

    // Simulation-only delay parameter has no hardware meaning.
    assign unused_delay = (DELAY != 0);

    assign op       = func_e'(func);
    assign sum_ext  = {1'b0, data1} + {1'b0, data2};
    assign diff_ext = {1'b0, data1} - {1'b0, data2};
    assign prod_u   = {{DATA_W{1'b0}}, data1} * {{DATA_W{1'b0}}, data2};
    // Sign-extended operands give the signed product modulo 2^PROD_W.
    assign prod_s   = {{DATA_W{data1[MSB]}}, data1} * {{DATA_W{data2[MSB]}}, data2};

`ifdef ALU_HILO_DIV_EN
    logic [DATA_W-1:0] quo_s, rem_s, quo_u, rem_u;

    // Divide by zero yields all-ones quotient and the dividend as remainder.
    always_comb begin
        quo_s = '1;
        rem_s = data1;
        quo_u = '1;
        rem_u = data1;
        if (data2 != '0) begin
            quo_s = DATA_W'($signed(data1) / $signed(data2));
            rem_s = DATA_W'($signed(data1) % $signed(data2));
            quo_u = data1 / data2;
            rem_u = data1 % data2;
        end
    end
`endif

    // Result, flags and HI/LO next state.
    always_comb begin
        res      = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        hi_nxt   = hi;
        lo_nxt   = lo;
        case (op)
            FN_ADD, FN_ADDU: begin
                res      = sum_ext[MSB:0];
                carry    = sum_ext[DATA_W];
                overflow = (data1[MSB] == data2[MSB]) && (sum_ext[MSB] != data1[MSB]);
            end
            FN_SUB, FN_SUBU: begin
                res      = diff_ext[MSB:0];
                carry    = diff_ext[DATA_W];
                overflow = (data1[MSB] != data2[MSB]) && (diff_ext[MSB] != data1[MSB]);
            end
            FN_AND:  res = data1 & data2;
            FN_OR:   res = data1 | data2;
            FN_XOR:  res = data1 ^ data2;
            FN_NOR:  res = ~(data1 | data2);
            FN_SLT:  res = DATA_W'($signed(data1) < $signed(data2));
            FN_SLTU: res = DATA_W'(data1 < data2);
            FN_SLL:  res = data1 << shamt;
            FN_SRL:  res = data1 >> shamt;
            FN_SRA:  res = DATA_W'($signed(data1) >>> shamt);
            FN_MULT: {hi_nxt, lo_nxt} = prod_s;
            FN_MULU: {hi_nxt, lo_nxt} = prod_u;
`ifdef ALU_HILO_DIV_EN
            FN_DIV: begin
                hi_nxt = rem_s;
                lo_nxt = quo_s;
            end
            FN_DIVU: begin
                hi_nxt = rem_u;
                lo_nxt = quo_u;
            end
`endif
            FN_MFHI: res = hi;
            FN_MFLO: res = lo;
            FN_MTHI: hi_nxt = data1;
            FN_MTLO: lo_nxt = data1;
            default: res = '0;
        endcase
    end

    assign result = res;
    assign status = {carry, overflow, res[MSB], (res == '0)};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_alu_hilo.sv
// Self-checking bench for alu_hilo at DATA_W=4: directed vectors plus a randomized
// run against an integer-arithmetic reference model. Honours ALU_HILO_DIV_EN.
module tb_alu_hilo;
    localparam int unsigned W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data1, data2, result;
    logic [4:0]   func;
    logic [1:0]   shamt;
    logic [3:0]   status;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [W-1:0] e_res, e_hi, e_lo;
    logic [3:0]   e_st;

    typedef struct packed {
        logic [4:0] f;
        logic [3:0] a, b;
        logic [1:0] s;
        logic [3:0] r, st;
    } vec_t;

    alu_hilo #(.DATA_W(W), .DELAY(0)) dut (
        .clock (clock),
        .reset (reset),
        .data1 (data1),
        .data2 (data2),
        .func  (func),
        .shamt (shamt),
        .result(result),
        .status(status)
    );

    always #5 clock = ~clock;

    function automatic int sx(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic void model(input logic [4:0] f, input logic [3:0] a, input logic [3:0] b,
                                  input logic [1:0] s, output logic [3:0] res, output logic [3:0] st,
                                  output logic [3:0] hn, output logic [3:0] ln);
        int   t, t2, q;
        logic c, v;
        res = '0; c = 1'b0; v = 1'b0; hn = m_hi; ln = m_lo;
        case (int'(f))
            1, 2: begin
                t = int'(a) + int'(b); res = t[3:0]; c = (t > 15);
                t2 = sx(a) + sx(b); v = (t2 > 7) || (t2 < -8);
            end
            3, 4: begin
                t = int'(a) - int'(b); res = t[3:0]; c = (a < b);
                t2 = sx(a) - sx(b); v = (t2 > 7) || (t2 < -8);
            end
            5: res = a & b;
            6: res = a | b;
            7: res = a ^ b;
            8: res = ~(a | b);
            9: res = (sx(a) < sx(b)) ? 4'd1 : 4'd0;
            10: res = (a < b) ? 4'd1 : 4'd0;
            11: begin t = int'(a) << s; res = t[3:0]; end
            12: begin t = int'(a) >> s; res = t[3:0]; end
            13: begin t = sx(a) >>> s; res = t[3:0]; end
            14: begin t = sx(a) * sx(b); hn = t[7:4]; ln = t[3:0]; end
            15: begin t = int'(a) * int'(b); hn = t[7:4]; ln = t[3:0]; end
`ifdef ALU_HILO_DIV_EN
            16, 17: begin
                if (b == 4'd0) begin
                    hn = a; ln = 4'hF;
                end else if (f == 5'd16) begin
                    q = sx(a) / sx(b); t = sx(a) % sx(b); ln = q[3:0]; hn = t[3:0];
                end else begin
                    q = int'(a) / int'(b); t = int'(a) % int'(b); ln = q[3:0]; hn = t[3:0];
                end
            end
`endif
            18: res = m_hi;
            19: res = m_lo;
            20: hn = a;
            21: ln = a;
            default: res = '0;
        endcase
        st = {c, v, res[3], (res == 4'd0)};
    endfunction

    task automatic step(input logic [4:0] f, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        @(negedge clock);
        func = f; data1 = a; data2 = b; shamt = s;
        #1;
        model(f, a, b, s, e_res, e_st, e_hi, e_lo);
    endtask

    task automatic commit();
        @(posedge clock);
        #1;
        if (reset) begin m_hi = e_hi; m_lo = e_lo; end
        else begin m_hi = '0; m_lo = '0; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(5'd18, 4'h3, 4'h5, 2'd0);
        n_checks++; if (result !== 4'h0) begin n_fail++; $display("FAIL reset_mfhi result got %h want 0", result); end
        n_checks++; if (status !== 4'b0001) begin n_fail++; $display("FAIL reset_mfhi status got %b want 0001", status); end
        step(5'd19, 4'h3, 4'h5, 2'd0);
        n_checks++; if (result !== 4'h0) begin n_fail++; $display("FAIL reset_mflo result got %h want 0", result); end
        n_checks++; if (status !== 4'b0001) begin n_fail++; $display("FAIL reset_mflo status got %b want 0001", status); end
        commit();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t tbl[$];
        tbl.push_back({5'd1,  4'h7, 4'h3, 2'd0, 4'hA, 4'b0110});
        tbl.push_back({5'd7,  4'hF, 4'hF, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd15, 4'hA, 4'hA, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'h6, 4'b0000});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h4, 4'b0000});
        tbl.push_back({5'd8,  4'h5, 4'h3, 2'd0, 4'h8, 4'b0010});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'h6, 4'b0000});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h4, 4'b0000});
        tbl.push_back({5'd20, 4'hA, 4'h0, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'hA, 4'b0010});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h4, 4'b0000});
        tbl.push_back({5'd11, 4'h5, 4'h0, 2'd1, 4'hA, 4'b0010});
        tbl.push_back({5'd13, 4'hA, 4'h0, 2'd1, 4'hD, 4'b0010});
        tbl.push_back({5'd12, 4'hA, 4'h0, 2'd2, 4'h2, 4'b0000});
        tbl.push_back({5'd3,  4'h0, 4'h1, 2'd0, 4'hF, 4'b1010});
        tbl.push_back({5'd1,  4'hF, 4'h1, 2'd0, 4'h0, 4'b1001});
        tbl.push_back({5'd3,  4'h8, 4'h1, 2'd0, 4'h7, 4'b0100});
        tbl.push_back({5'd9,  4'h8, 4'h7, 2'd0, 4'h1, 4'b0000});
        tbl.push_back({5'd10, 4'h8, 4'h7, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd14, 4'hF, 4'hF, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h1, 4'b0000});
        tbl.push_back({5'd14, 4'h7, 4'h8, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'hC, 4'b0010});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h8, 4'b0010});
        tbl.push_back({5'd21, 4'h3, 4'h0, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h3, 4'b0000});
        tbl.push_back({5'd21, 4'hC, 4'h0, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd21, 4'h6, 4'h0, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h6, 4'b0000});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'hC, 4'b0010});
`ifdef ALU_HILO_DIV_EN
        tbl.push_back({5'd17, 4'h7, 4'h2, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'h1, 4'b0000});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h3, 4'b0000});
        tbl.push_back({5'd17, 4'h9, 4'h0, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'h9, 4'b0010});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'hF, 4'b0010});
        tbl.push_back({5'd16, 4'h9, 4'h2, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'hF, 4'b0010});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'hD, 4'b0010});
`else
        tbl.push_back({5'd17, 4'h7, 4'h2, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'hC, 4'b0010});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h6, 4'b0000});
        tbl.push_back({5'd16, 4'h9, 4'h0, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd18, 4'h0, 4'h0, 2'd0, 4'hC, 4'b0010});
        tbl.push_back({5'd19, 4'h0, 4'h0, 2'd0, 4'h6, 4'b0000});
`endif
        tbl.push_back({5'd25, 4'h5, 4'h5, 2'd0, 4'h0, 4'b0001});
        tbl.push_back({5'd0,  4'hF, 4'hF, 2'd0, 4'h0, 4'b0001});
        foreach (tbl[i]) begin
            step(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].s);
            n_checks++;
            if (result !== tbl[i].r) begin
                n_fail++; $display("FAIL directed[%0d] func=%0d result got %h want %h", i, tbl[i].f, result, tbl[i].r);
            end
            n_checks++;
            if (status !== tbl[i].st) begin
                n_fail++; $display("FAIL directed[%0d] func=%0d status got %b want %b", i, tbl[i].f, status, tbl[i].st);
            end
            commit();
        end
    endtask

    task automatic test_async_reset();
        step(5'd20, 4'h5, 4'h0, 2'd0);
        commit();
        step(5'd18, 4'h0, 4'h0, 2'd0);
        n_checks++; if (result !== 4'h5) begin n_fail++; $display("FAIL pre_reset_mfhi result got %h want 5", result); end
        reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        n_checks++; if (result !== 4'h0) begin n_fail++; $display("FAIL async_clear result got %h want 0", result); end
        n_checks++; if (status !== 4'b0001) begin n_fail++; $display("FAIL async_clear status got %b want 0001", status); end
        func = 5'd20; data1 = 4'h9;
        @(posedge clock);
        #1;
        func = 5'd18;
        #1;
        n_checks++; if (result !== 4'h0) begin n_fail++; $display("FAIL reset_override result got %h want 0", result); end
        @(negedge clock);
        reset = 1'b1; func = 5'd19;
        step(5'd18, 4'h0, 4'h0, 2'd0);
        n_checks++; if (result !== 4'h0) begin n_fail++; $display("FAIL post_release_mfhi result got %h want 0", result); end
        commit();
    endtask

    task automatic test_random();
        logic [4:0] f;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) f = 5'(18 + $urandom_range(0, 1));
            else f = 5'($urandom_range(0, 31));
            step(f, 4'($urandom), 4'($urandom), 2'($urandom));
            n_checks++;
            if (result !== e_res) begin
                n_fail++; $display("FAIL random[%0d] func=%0d result got %h want %h", i, f, result, e_res);
            end
            n_checks++;
            if (status !== e_st) begin
                n_fail++; $display("FAIL random[%0d] func=%0d status got %b want %b", i, f, status, e_st);
            end
            commit();
        end
    endtask

    initial begin
        reset = 1'b0;
        func = 5'd18; data1 = '0; data2 = '0; shamt = '0;
        test_reset();
        test_directed();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
